// File: rtl/phase_pkg.sv
// Shared types and constants for the phase differentiator slice.
package phase_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam int WIDTH_DEF       = 14;
    localparam int ACC_WIDTH_DEF   = 24;
    localparam int DECIM_WIDTH_DEF = 16;

    localparam logic signed [ACC_WIDTH_DEF-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH_DEF-1){1'b1}}};
    localparam logic signed [ACC_WIDTH_DEF-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH_DEF-1){1'b0}}};

endpackage

// File: rtl/phase_differentiator_sat_accumulator.sv
// Combinational signed add of a narrow delta into a wide accumulator, clamped to the
// accumulator's signed range, with an overflow flag.
module sat_accumulator #(
    parameter int WIDTH     = 14,
    parameter int ACC_WIDTH = 24
) (
    input  logic signed [ACC_WIDTH-1:0] acc_i,
    input  logic signed [WIDTH-1:0]     delta_i,
    output logic signed [ACC_WIDTH-1:0] sum_o,
    output logic                        ovf_o
);

    localparam logic signed [ACC_WIDTH-1:0] LIM_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] LIM_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic [ACC_WIDTH:0] wide;

    // One guard bit: overflow iff the two top bits disagree.
    assign wide = {acc_i[ACC_WIDTH-1], acc_i}
                + {{(ACC_WIDTH+1-WIDTH){delta_i[WIDTH-1]}}, delta_i};

    always_comb begin
        sum_o = wide[ACC_WIDTH-1:0];
        ovf_o = 1'b0;
        if (wide[ACC_WIDTH] != wide[ACC_WIDTH-1]) begin
            ovf_o = 1'b1;
            sum_o = wide[ACC_WIDTH] ? LIM_MIN : LIM_MAX;
        end
    end

endmodule

// File: rtl/phase_differentiator.sv
// Recovers modulo-one-turn phase increments from a wrapped phase stream and
// integrates them over a programmable window into a decimated frequency estimate.
module phase_differentiator
    import phase_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
    parameter int DECIM_WIDTH = DECIM_WIDTH_DEF
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic signed [WIDTH-1:0]       data_i,
    input  logic                          valid_i,
    input  logic        [DECIM_WIDTH-1:0] decim_i,
    input  logic                          clear_i,
    output logic signed [WIDTH-1:0]       delta_o,
    output logic                          delta_valid_o,
    output logic signed [ACC_WIDTH-1:0]   freq_o,
    output logic                          freq_valid_o,
    output logic                          sat_o
);

    state_e                        state_q, state_d;
    logic signed [WIDTH-1:0]       prev_q, prev_d;
    logic signed [WIDTH-1:0]       delta_q, delta_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic signed [ACC_WIDTH-1:0]   freq_q, freq_d;
    logic        [DECIM_WIDTH-1:0] count_q, count_d;
    logic        [DECIM_WIDTH-1:0] win_q, win_d;
    logic                          dvld_q, dvld_d;
    logic                          fvld_q, fvld_d;
    logic                          sat_q, sat_d;

    logic signed [WIDTH-1:0]       diff;
    logic signed [ACC_WIDTH-1:0]   sum;
    logic                          ovf;
    logic        [DECIM_WIDTH-1:0] win_eff;
    logic                          last;

    assign diff = data_i - prev_q;

    // A new window samples decim_i on its first delta; later deltas use the latched length.
    assign win_eff = (count_q != '0)  ? win_q
                   : (decim_i == '0)  ? DECIM_WIDTH'(1) : decim_i;
    assign last    = (count_q == win_eff - DECIM_WIDTH'(1));

    sat_accumulator #(
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_sat_acc (
        .acc_i   (acc_q),
        .delta_i (diff),
        .sum_o   (sum),
        .ovf_o   (ovf)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= EMPTY;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = EMPTY;
        end else if (valid_i) begin
            case (state_q)
                EMPTY:   state_d = RUN;
                RUN:     state_d = RUN;
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        delta_o       = delta_q;
        delta_valid_o = dvld_q;
        freq_o        = freq_q;
        freq_valid_o  = fvld_q;
        sat_o         = sat_q;
    end

    always_comb begin
        prev_d  = prev_q;
        delta_d = delta_q;
        acc_d   = acc_q;
        freq_d  = freq_q;
        count_d = count_q;
        win_d   = win_q;
        sat_d   = sat_q;
        dvld_d  = 1'b0;
        fvld_d  = 1'b0;
        if (clear_i) begin
            acc_d   = '0;
            count_d = '0;
            sat_d   = 1'b0;
        end else if (valid_i) begin
            prev_d = data_i;
            if (state_q == RUN) begin
                delta_d = diff;
                dvld_d  = 1'b1;
                win_d   = win_eff;
                sat_d   = sat_q | ovf;
                if (last) begin
                    freq_d  = sum;
                    fvld_d  = 1'b1;
                    acc_d   = '0;
                    count_d = '0;
                end else begin
                    acc_d   = sum;
                    count_d = count_q + DECIM_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q  <= '0;
            delta_q <= '0;
            acc_q   <= '0;
            freq_q  <= '0;
            count_q <= '0;
            win_q   <= '0;
            dvld_q  <= 1'b0;
            fvld_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            delta_q <= delta_d;
            acc_q   <= acc_d;
            freq_q  <= freq_d;
            count_q <= count_d;
            win_q   <= win_d;
            dvld_q  <= dvld_d;
            fvld_q  <= fvld_d;
            sat_q   <= sat_d;
        end
    end

endmodule

// File: tb/tb_phase_differentiator.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a negedge monitor pops on strobes.
module tb_phase_differentiator;

    localparam int W  = 14;
    localparam int AW = 16;
    localparam int DW = 16;

    logic                 clk;
    logic                 rst_n;
    logic signed [W-1:0]  data_i;
    logic                 valid_i;
    logic [DW-1:0]        decim_i;
    logic                 clear_i;
    logic signed [W-1:0]  delta_o;
    logic                 delta_valid_o;
    logic signed [AW-1:0] freq_o;
    logic                 freq_valid_o;
    logic                 sat_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int d;
        bit fv;
        int f;
        int cyc;
    } exp_t;

    exp_t sb[$];

    phase_differentiator #(
        .WIDTH       (W),
        .ACC_WIDTH   (AW),
        .DECIM_WIDTH (DW)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .data_i        (data_i),
        .valid_i       (valid_i),
        .decim_i       (decim_i),
        .clear_i       (clear_i),
        .delta_o       (delta_o),
        .delta_valid_o (delta_valid_o),
        .freq_o        (freq_o),
        .freq_valid_o  (freq_valid_o),
        .sat_o         (sat_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (delta_valid_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_delta_strobe", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("delta_o", delta_o, e.d);
                    chk("delta_latency_cycle", cyc, e.cyc);
                    chk("freq_valid_o", freq_valid_o, e.fv);
                    if (e.fv) chk("freq_o", freq_o, e.f);
                end
            end else if (freq_valid_o) begin
                chk("freq_strobe_without_delta", 1, 0);
            end
        end
    end

    // Drives one sample; called #1 after a posedge, returns #1 after the capturing posedge.
    task automatic send(input int s, input bit has_exp, input int d = 0,
                        input bit fv = 0, input int f = 0);
        exp_t e;
        if (has_exp) begin
            e.d = d; e.fv = fv; e.f = f; e.cyc = cyc + 1;
            sb.push_back(e);
        end
        data_i  = s[W-1:0];
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        @(posedge clk);
        #1;
        clear_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [W-1:0] p;
        rst_n   = 1'b0;
        data_i  = '0;
        valid_i = 1'b0;
        decim_i = '0;
        clear_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_delta_o", delta_o, 0);
        chk("reset_freq_o", freq_o, 0);
        chk("reset_sat_o", sat_o, 0);
        chk("reset_delta_valid", delta_valid_o, 0);
        chk("reset_freq_valid", freq_valid_o, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Wrap handling with decim 0: every delta is also a window result.
        decim_i = 0;
        send(8190, 0);
        send(-8191, 1, 3, 1, 3);
        send(8190, 1, -3, 1, -3);
        send(0, 1, -8190, 1, -8190);
        send(-8192, 1, -8192, 1, -8192);
        drain();
        chk("delta_o_holds", delta_o, -8192);
        do_clear();
        chk("clear_keeps_delta_o", delta_o, -8192);
        chk("clear_keeps_freq_o", freq_o, -8192);

        // Decimation by 4 over a constant ramp, back-to-back samples.
        decim_i = 4;
        send(0, 0);
        for (int i = 1; i <= 8; i++) send(i * 100, 1, 100, (i % 4) == 0, 400);
        drain();
        do_clear();

        // decim change mid-window takes effect at the next window.
        decim_i = 4;
        send(0, 0);
        send(10, 1, 10, 0, 0);
        send(20, 1, 10, 0, 0);
        decim_i = 2;
        send(30, 1, 10, 0, 0);
        send(40, 1, 10, 1, 40);
        send(50, 1, 10, 0, 0);
        send(60, 1, 10, 1, 20);
        drain();
        do_clear();

        // Saturation: 8 x 8191 clamps at 32767; sat stays through the next window.
        decim_i = 8;
        p = 0;
        send(p, 0);
        for (int i = 0; i < 8; i++) begin
            p = p + 14'sd8191;
            send(p, 1, 8191, i == 7, 32767);
        end
        drain();
        chk("sat_set", sat_o, 1);
        for (int i = 0; i < 8; i++) begin
            p = p + 14'sd1;
            send(p, 1, 1, i == 7, 8);
        end
        drain();
        chk("sat_sticky", sat_o, 1);
        do_clear();
        chk("sat_cleared", sat_o, 0);

        // clear together with valid mid-window: sample dropped, next sample re-primes.
        decim_i = 4;
        send(0, 0);
        send(5, 1, 5, 0, 0);
        send(10, 1, 5, 0, 0);
        drain();
        clear_i = 1'b1;
        valid_i = 1'b1;
        data_i  = 15;
        @(posedge clk);
        #1;
        clear_i = 1'b0;
        valid_i = 1'b0;
        send(100, 0);
        send(104, 1, 4, 0, 0);
        send(108, 1, 4, 0, 0);
        send(112, 1, 4, 0, 0);
        send(116, 1, 4, 1, 16);
        drain();

        // Async reset between edges mid-window.
        send(123, 1, 7, 0, 0);
        send(130, 1, 7, 0, 0);
        drain();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_delta_o", delta_o, 0);
        chk("async_rst_freq_o", freq_o, 0);
        chk("async_rst_sat_o", sat_o, 0);
        chk("async_rst_delta_valid", delta_valid_o, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(50, 0);
        send(53, 1, 3, 0, 0);
        send(56, 1, 3, 0, 0);
        send(59, 1, 3, 0, 0);
        send(62, 1, 3, 1, 12);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
